// File: rtl/uart_alu_ctrl.sv
// Packet controller between the UART RX and TX byte streams.
// It parses framed commands, then either echoes the payload or returns a 32-bit add/sub reduction.
module uart_alu_ctrl #(
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 32'h0000_FFFF
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] rx_tdata_i,
    input  logic                  rx_tvalid_i,
    output logic                  rx_tready_o,
    output logic [DATA_WIDTH-1:0] tx_tdata_o,
    output logic                  tx_tvalid_o,
    input  logic                  tx_tready_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_SUB  = 8'hA1;

    typedef enum logic [2:0] {HDR, ECHO, ACC, TX, DRAIN, ERR} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  hdr_cnt_reg, hdr_cnt_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [1:0]  tx_cnt_reg, tx_cnt_next;
    logic [7:0]  opcode_reg, opcode_next;
    logic [7:0]  len_lo_reg, len_lo_next;
    logic [15:0] remaining_reg, remaining_next;
    logic [23:0] shift_reg, shift_next;
    logic        first_reg, first_next;
    logic [31:0] acc_reg, acc_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        busy_reg, busy_next;
    logic        err_reg, err_next;
    logic        run_reg;

    logic        rx_ready;
    logic        rx_fire;
    logic [15:0] hdr_len;
    logic [15:0] payload_len;
    logic [31:0] operand;

    // run_reg keeps the input closed during reset and for the first cycle after release.
    assign rx_tready_o = run_reg & rx_ready;
    assign rx_fire     = rx_tvalid_i & rx_tready_o;
    assign hdr_len     = {rx_tdata_i, len_lo_reg};
    assign payload_len = hdr_len - 16'd4;
    assign operand     = {rx_tdata_i, shift_reg};

    assign tx_tdata_o  = tx_data_reg;
    assign tx_tvalid_o = tx_valid_reg;
    assign busy_o      = busy_reg;
    assign err_o       = err_reg;

    always_comb begin
        rx_ready = 1'b0;
        case (state_reg)
            HDR:     rx_ready = !tx_valid_reg;
            ECHO:    rx_ready = !tx_valid_reg || tx_tready_i;
            ACC:     rx_ready = 1'b1;
            DRAIN:   rx_ready = (remaining_reg != 16'd0);
            default: rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        tx_cnt_next    = tx_cnt_reg;
        opcode_next    = opcode_reg;
        len_lo_next    = len_lo_reg;
        remaining_next = remaining_reg;
        shift_next     = shift_reg;
        first_next     = first_reg;
        acc_next       = acc_reg;
        tx_data_next   = tx_data_reg;
        tx_valid_next  = tx_valid_reg & ~tx_tready_i;
        err_next       = 1'b0;

        case (state_reg)
            HDR: begin
                if (rx_fire) begin
                    hdr_cnt_next = hdr_cnt_reg + 2'd1;
                    case (hdr_cnt_reg)
                        2'd0: opcode_next = rx_tdata_i;
                        2'd2: len_lo_next = rx_tdata_i;
                        2'd3: begin
                            remaining_next = payload_len;
                            byte_cnt_next  = 2'd0;
                            first_next     = 1'b1;
                            tx_cnt_next    = 2'd0;
                            if (hdr_len < 16'd4 || 32'(hdr_len) > MAX_LEN) begin
                                state_next = ERR;
                                err_next   = 1'b1;
                            end else if (opcode_reg == OP_ECHO) begin
                                if (payload_len != 16'd0) state_next = ECHO;
                            end else if ((opcode_reg == OP_ADD || opcode_reg == OP_SUB) &&
                                         payload_len != 16'd0 && payload_len[1:0] == 2'b00) begin
                                state_next = ACC;
                            end else begin
                                state_next = DRAIN;
                                err_next   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ECHO: begin
                if (rx_fire) begin
                    tx_data_next   = rx_tdata_i;
                    tx_valid_next  = 1'b1;
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd1) state_next = HDR;
                end
            end
            ACC: begin
                if (rx_fire) begin
                    shift_next     = {rx_tdata_i, shift_reg[23:8]};
                    byte_cnt_next  = byte_cnt_reg + 2'd1;
                    remaining_next = remaining_reg - 16'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        first_next = 1'b0;
                        if (first_reg)                acc_next = operand;
                        else if (opcode_reg == OP_SUB) acc_next = acc_reg - operand;
                        else                          acc_next = acc_reg + operand;
                        if (remaining_reg == 16'd1) state_next = TX;
                    end
                end
            end
            TX: begin
                // The accumulator is shifted down as bytes leave, so the next byte is always [7:0].
                if (!tx_valid_reg) begin
                    tx_data_next  = acc_reg[7:0];
                    acc_next      = {8'd0, acc_reg[31:8]};
                    tx_valid_next = 1'b1;
                end else if (tx_tready_i) begin
                    if (tx_cnt_reg == 2'd3) begin
                        tx_cnt_next = 2'd0;
                        state_next  = HDR;
                    end else begin
                        tx_cnt_next   = tx_cnt_reg + 2'd1;
                        tx_data_next  = acc_reg[7:0];
                        acc_next      = {8'd0, acc_reg[31:8]};
                        tx_valid_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (remaining_reg == 16'd0) begin
                    state_next = HDR;
                end else if (rx_fire) begin
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd1) state_next = HDR;
                end
            end
            ERR:     state_next = HDR;
            default: state_next = HDR;
        endcase

        busy_next = !(state_next == HDR && hdr_cnt_next == 2'd0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg     <= HDR;
            hdr_cnt_reg   <= 2'd0;
            byte_cnt_reg  <= 2'd0;
            tx_cnt_reg    <= 2'd0;
            opcode_reg    <= 8'd0;
            len_lo_reg    <= 8'd0;
            remaining_reg <= 16'd0;
            shift_reg     <= 24'd0;
            first_reg     <= 1'b0;
            acc_reg       <= 32'd0;
            tx_data_reg   <= 8'd0;
            tx_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            run_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            tx_cnt_reg    <= tx_cnt_next;
            opcode_reg    <= opcode_next;
            len_lo_reg    <= len_lo_next;
            remaining_reg <= remaining_next;
            shift_reg     <= shift_next;
            first_reg     <= first_next;
            acc_reg       <= acc_next;
            tx_data_reg   <= tx_data_next;
            tx_valid_reg  <= tx_valid_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
            run_reg       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: packets are scored against a packet-level model
// that turns each command into its expected reply bytes and error pulses.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_tdata = 8'd0;
    logic       rx_tvalid = 1'b0;
    logic       rx_tready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready = 1'b1;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;  // 0 always ready, 1 one-of-three, 2 random, 3 driven by the test

    logic [7:0] pkt[$];
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         lat_q[$];
    int         err_cycles;
    int         stall_viol;
    int         last_rx_cyc;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'd0;

    uart_alu_ctrl dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .rx_tdata_i  (rx_tdata),
        .rx_tvalid_i (rx_tvalid),
        .rx_tready_o (rx_tready),
        .tx_tdata_o  (tx_tdata),
        .tx_tvalid_o (tx_tvalid),
        .tx_tready_i (tx_tready),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_tready = 1'b1;
            1: tx_tready = (cyc % 3 == 0);
            2: tx_tready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Passive monitor: TX bytes, handshake cycles, first-byte latency, err pulses, stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (rx_tvalid && rx_tready) last_rx_cyc = cyc;
            if (tx_tvalid && !prev_valid) lat_q.push_back(cyc - last_rx_cyc);
            if (prev_stall && (!tx_tvalid || tx_tdata !== prev_data)) stall_viol++;
            if (tx_tvalid && tx_tready) begin
                got_q.push_back(tx_tdata);
                got_cyc.push_back(cyc);
            end
            if (err) err_cycles++;
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_tdata;
            prev_valid = tx_tvalid;
        end
    end

    task automatic clear_sb();
        got_q.delete();
        got_cyc.delete();
        lat_q.delete();
        exp_q.delete();
        exp_err    = 0;
        err_cycles = 0;
        stall_viol = 0;
    endtask

    // Packet-level reference: what the host should see back for one command.
    task automatic model_pkt();
        int          len;
        logic [31:0] acc;
        logic [31:0] op;
        len = int'({pkt[3], pkt[2]});
        acc = 32'd0;
        if (len < 4) begin
            exp_err++;
        end else if (pkt[0] == 8'hEC) begin
            for (int i = 4; i < len; i++) exp_q.push_back(pkt[i]);
        end else if ((pkt[0] == 8'hA0 || pkt[0] == 8'hA1) && len > 4 && len % 4 == 0) begin
            for (int k = 0; k < (len - 4) / 4; k++) begin
                op = {pkt[4*k+7], pkt[4*k+6], pkt[4*k+5], pkt[4*k+4]};
                if (k == 0)              acc = op;
                else if (pkt[0] == 8'hA0) acc = acc + op;
                else                     acc = acc - op;
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
        end else begin
            exp_err++;
        end
    endtask

    task automatic build_arith(input logic [7:0] op, input int n);
        int len;
        len = 4 + 4 * n;
        pkt.delete();
        pkt.push_back(op);
        pkt.push_back(8'($urandom));
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        repeat (4 * n) pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    endtask

    task automatic build_echo(input logic [7:0] op, input int n);
        int len;
        len = 4 + n;
        pkt.delete();
        pkt.push_back(op);
        pkt.push_back(8'($urandom));
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        repeat (n) pkt.push_back(8'($urandom));
    endtask

    task automatic send_pkt(input int gap_max);
        model_pkt();
        @(posedge clk);
        #1;
        foreach (pkt[i]) begin
            int t;
            bit done;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            rx_tdata  = pkt[i];
            rx_tvalid = 1'b1;
            t    = 0;
            done = 1'b0;
            while (!done && t < 500) begin
                @(negedge clk);
                done = rx_tready;
                @(posedge clk);
                #1;
                t++;
            end
            rx_tvalid = 1'b0;
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL rx_accept: byte %0d got no handshake in 500 cycles, want accepted", i);
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (t < 4000 && !(got_q.size() >= exp_q.size() && !busy && !tx_tvalid)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d bytes busy=%0b, want %0d bytes and idle", got_q.size(), busy, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (rx_tready !== 1'b0) begin errors++; $display("FAIL reset_rx_tready: got %b want 0", rx_tready); end
        if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tx_tvalid: got %b want 0", tx_tvalid); end
        if (tx_tdata !== 8'h00) begin errors++; $display("FAIL reset_tx_tdata: got %h want 00", tx_tdata); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (rx_tready !== 1'b1) begin errors++; $display("FAIL idle_rx_tready: got %b want 1", rx_tready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_add();
        clear_sb();
        ready_mode = 0;
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        wait_idle();
        checks += 2;
        if (lat_q.size() != 1 || lat_q[0] != 2) begin
            errors++;
            $display("FAIL add_latency: got %0d rises first=%0d, want 1 rise at 2", lat_q.size(), (lat_q.size() > 0) ? lat_q[0] : -1);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b want 0", busy); end
        for (int r = 0; r < 3; r++) begin
            build_arith(8'hA0, $urandom_range(1, 5));
            send_pkt(2);
        end
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL add_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL add_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (err_cycles != 0) begin errors++; $display("FAIL add_err: got %0d pulses want 0", err_cycles); end
    endtask

    task automatic test_sub_backpressure();
        clear_sb();
        ready_mode = 1;
        pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            build_arith(8'hA1, $urandom_range(1, 4));
            send_pkt(1);
        end
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sub_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sub_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks += 2;
        if (stall_viol != 0) begin errors++; $display("FAIL sub_stall_stable: got %0d changes while stalled want 0", stall_viol); end
        if (err_cycles != 0) begin errors++; $display("FAIL sub_err: got %0d pulses want 0", err_cycles); end
        ready_mode = 0;
    endtask

    task automatic test_echo();
        clear_sb();
        ready_mode = 0;
        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_pkt(0);
        pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
        send_pkt(0);
        wait_idle();
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL echo_count: got %0d bytes want 3", got_q.size());
        end else for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL echo_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (got_cyc[i] != got_cyc[i-1] + 1) begin
                    errors++;
                    $display("FAIL echo_rate%0d: got gap %0d cycles want 1", i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        clear_sb();
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            build_echo(8'hEC, $urandom_range(1, 9));
            send_pkt(1);
        end
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL echo_rand_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL echo_rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL echo_stall_stable: got %0d want 0", stall_viol); end
        ready_mode = 0;
    endtask

    task automatic test_bad_opcode();
        clear_sb();
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(0);
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        wait_idle();
        checks += 2;
        if (err_cycles != 1) begin errors++; $display("FAIL badop_err: got %0d pulse cycles want 1", err_cycles); end
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL badop_count: got %0d bytes want 4", got_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL badop_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_len_error();
        clear_sb();
        pkt = '{8'hA0, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        send_pkt(0);
        wait_idle();
        checks += 2;
        if (err_cycles != 1) begin errors++; $display("FAIL len6_err: got %0d pulse cycles want 1", err_cycles); end
        if (got_q.size() != 0) begin errors++; $display("FAIL len6_tx: got %0d bytes want 0", got_q.size()); end
        clear_sb();
        pkt = '{8'hA0, 8'h00, 8'h02, 8'h00};
        send_pkt(0);
        wait_idle();
        checks += 3;
        if (err_cycles != exp_err) begin errors++; $display("FAIL len2_err: got %0d pulse cycles want %0d", err_cycles, exp_err); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL len2_busy: got %b want 0", busy); end
        if (rx_tready !== 1'b1)  begin errors++; $display("FAIL len2_rx_tready: got %b want 1", rx_tready); end
    endtask

    task automatic test_reset_mid_tx();
        int t = 0;
        clear_sb();
        ready_mode = 3;
        tx_tready  = 1'b0;
        build_arith(8'hA0, 2);
        send_pkt(0);
        while (!tx_tvalid && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!tx_tvalid) begin errors++; $display("FAIL midtx_valid: got 0 want 1 before reset"); end
        @(posedge clk); #1; tx_tready = 1'b1;
        @(posedge clk); #1; tx_tready = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_tvalid !== 1'b1 || tx_tdata !== exp_q[1]) begin
            errors++;
            $display("FAIL midtx_byte1: got v=%b d=%h want v=1 d=%h", tx_tvalid, tx_tdata, exp_q[1]);
        end
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL midtx_rst_valid: got %b want 0", tx_tvalid); end
        if (rx_tready !== 1'b0) begin errors++; $display("FAIL midtx_rst_ready: got %b want 0", rx_tready); end
        if (tx_tdata !== 8'h00) begin errors++; $display("FAIL midtx_rst_data: got %h want 00", tx_tdata); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL midtx_rst_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        clear_sb();
        build_arith(8'hA0, 2);
        send_pkt(0);
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL postrst_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL postrst_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        clear_sb();
        ready_mode = 2;
        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 4))
                0: build_echo(8'hEC, $urandom_range(0, 8));
                1: build_arith(8'hA0, $urandom_range(0, 4));
                2: build_arith(8'hA1, $urandom_range(0, 4));
                3: build_echo(8'hA0, $urandom_range(1, 3) * 4 + $urandom_range(1, 3));
                default: begin
                    op = 8'($urandom);
                    if (op == 8'hEC || op == 8'hA0 || op == 8'hA1) op = 8'h55;
                    build_echo(op, $urandom_range(0, 6));
                end
            endcase
            send_pkt(1);
        end
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mix_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mix_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks += 2;
        if (err_cycles != exp_err) begin errors++; $display("FAIL mix_err: got %0d pulse cycles want %0d", err_cycles, exp_err); end
        if (stall_viol != 0)       begin errors++; $display("FAIL mix_stall_stable: got %0d want 0", stall_viol); end
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_backpressure();
        test_echo();
        test_bad_opcode();
        test_len_error();
        test_reset_mid_tx();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
